// File: rtl/rc4_phase_sequencer.sv
// RC4 key-search phase sequencer: runs S-init, KSA and PRGA engines in turn,
// steps the key on PRGA failure and muxes the single-port S memory.
//
// Ports:
//   clk, reset_n      clock and synchronous active-low reset
//   go                start (or restart) the search when not busy
//   phase_start[2:0]  one-cycle start pulse, bit i = engine i
//   phase_done[2:0]   engine done flags; only the active engine is honoured
//   prga_fail         PRGA rejected the current key
//   eng_addr/data     packed per-engine memory requests, engine i at slice i
//   eng_wren[2:0]     per-engine write enables
//   mem_addr/data     to S memory, from the owning engine (0 when unowned)
//   mem_wren          to S memory, from the owning engine only
//   key               current candidate key
//   busy              searching
//   key_found         search ended with a hit
//   key_exhaust       search ended on the last key without a hit
//   phase_led[2:0]    one-hot active engine, 0 when none
module rc4_phase_sequencer #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int KEY_W = 24,
  parameter logic [KEY_W-1:0] KEY_FIRST = KEY_W'(24'h000000),
  parameter logic [KEY_W-1:0] KEY_LAST  = KEY_W'(24'h3FFFFF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  output logic [2:0]        phase_start,
  input  logic [2:0]        phase_done,
  input  logic              prga_fail,
  input  logic [3*AW-1:0]   eng_addr,
  input  logic [3*DW-1:0]   eng_data,
  input  logic [2:0]        eng_wren,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_data,
  output logic              mem_wren,
  output logic [KEY_W-1:0]  key,
  output logic              busy,
  output logic              key_found,
  output logic              key_exhaust,
  output logic [2:0]        phase_led
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ST_INIT   = 4'd1;
  localparam logic [3:0] WT_INIT   = 4'd2;
  localparam logic [3:0] ST_KSA    = 4'd3;
  localparam logic [3:0] WT_KSA    = 4'd4;
  localparam logic [3:0] ST_PRGA   = 4'd5;
  localparam logic [3:0] WT_PRGA   = 4'd6;
  localparam logic [3:0] NEXT_KEY  = 4'd7;
  localparam logic [3:0] FOUND     = 4'd8;
  localparam logic [3:0] EXHAUSTED = 4'd9;

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic [2:0]       owner;
  logic [2:0]       owner_nx;
  logic [KEY_W-1:0] key_nx;
  logic             idle_like;

  assign idle_like = (state == IDLE)
                   | (state == FOUND)
                   | (state == EXHAUSTED);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (go) state_nx = ST_INIT;
      end
      ST_INIT: state_nx = WT_INIT;
      WT_INIT: begin
        if (phase_done[0]) state_nx = ST_KSA;
      end
      ST_KSA: state_nx = WT_KSA;
      WT_KSA: begin
        if (phase_done[1]) state_nx = ST_PRGA;
      end
      ST_PRGA: state_nx = WT_PRGA;
      WT_PRGA: begin
        // A failure wins over a simultaneous done.
        if (prga_fail) begin
          if (key == KEY_LAST) state_nx = EXHAUSTED;
          else                 state_nx = NEXT_KEY;
        end else if (phase_done[2]) begin
          state_nx = FOUND;
        end
      end
      NEXT_KEY: state_nx = ST_INIT;
      FOUND: begin
        if (go) state_nx = ST_INIT;
      end
      EXHAUSTED: begin
        if (go) state_nx = ST_INIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory owner tracks the engine whose ST/WT pair we are in.
  always_comb begin
    owner_nx = 3'b000;
    case (state_nx)
      ST_INIT, WT_INIT: owner_nx = 3'b001;
      ST_KSA,  WT_KSA:  owner_nx = 3'b010;
      ST_PRGA, WT_PRGA: owner_nx = 3'b100;
      default:          owner_nx = 3'b000;
    endcase
  end

  always_comb begin
    key_nx = key;
    if (state == NEXT_KEY) begin
      key_nx = key + KEY_W'(1);
    end else if (idle_like && go) begin
      key_nx = KEY_FIRST;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 3'b000;
      key   <= KEY_FIRST;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      key   <= key_nx;
    end
  end

  always_comb begin
    phase_start = 3'b000;
    case (state)
      ST_INIT: phase_start = 3'b001;
      ST_KSA:  phase_start = 3'b010;
      ST_PRGA: phase_start = 3'b100;
      default: phase_start = 3'b000;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    unique case (1'b1)
      owner[0]: begin
        mem_addr = eng_addr[0*AW +: AW];
        mem_data = eng_data[0*DW +: DW];
        mem_wren = eng_wren[0];
      end
      owner[1]: begin
        mem_addr = eng_addr[1*AW +: AW];
        mem_data = eng_data[1*DW +: DW];
        mem_wren = eng_wren[1];
      end
      owner[2]: begin
        mem_addr = eng_addr[2*AW +: AW];
        mem_data = eng_data[2*DW +: DW];
        mem_wren = eng_wren[2];
      end
      default: begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
      end
    endcase
  end

  assign busy        = ~idle_like;
  assign key_found   = (state == FOUND);
  assign key_exhaust = (state == EXHAUSTED);
  assign phase_led   = owner;

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench for rc4_phase_sequencer: directed scenarios then random traffic,
// two instances (default keys, and a one-key range at 3) against a model.
module tb_rc4_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic [2:0]  phase_done;
  logic        prga_fail;
  logic [23:0] eng_addr;
  logic [23:0] eng_data;
  logic [2:0]  eng_wren;

  logic [2:0]  ps   [2];
  logic [7:0]  ma   [2];
  logic [7:0]  md   [2];
  logic        mw   [2];
  logic [23:0] ky   [2];
  logic        bz   [2];
  logic        kf   [2];
  logic        kx   [2];
  logic [2:0]  led  [2];

  int vectors = 0;
  int errs = 0;

  // model: mode 0 idle, 1 running, 2 found, 3 exhausted, 4 advancing key
  int          m_mode  [2];
  int          m_eng   [2];
  bit          m_pulse [2];
  logic [23:0] m_key   [2];
  logic [23:0] k_first [2];
  logic [23:0] k_last  [2];

  always #5 clk = ~clk;

  rc4_phase_sequencer dut0 (
    .clk(clk), .reset_n(reset_n), .go(go),
    .phase_start(ps[0]), .phase_done(phase_done),
    .prga_fail(prga_fail), .eng_addr(eng_addr),
    .eng_data(eng_data), .eng_wren(eng_wren),
    .mem_addr(ma[0]), .mem_data(md[0]), .mem_wren(mw[0]),
    .key(ky[0]), .busy(bz[0]), .key_found(kf[0]),
    .key_exhaust(kx[0]), .phase_led(led[0])
  );

  rc4_phase_sequencer #(
    .KEY_FIRST(24'h000003), .KEY_LAST(24'h000003)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .go(go),
    .phase_start(ps[1]), .phase_done(phase_done),
    .prga_fail(prga_fail), .eng_addr(eng_addr),
    .eng_data(eng_data), .eng_wren(eng_wren),
    .mem_addr(ma[1]), .mem_data(md[1]), .mem_wren(mw[1]),
    .key(ky[1]), .busy(bz[1]), .key_found(kf[1]),
    .key_exhaust(kx[1]), .phase_led(led[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d);
    if (!reset_n) begin
      m_mode[d] = 0; m_pulse[d] = 0; m_eng[d] = 0;
      m_key[d] = k_first[d];
    end else begin
      case (m_mode[d])
        0, 2, 3: if (go) begin
          if (m_mode[d] != 0) m_key[d] = k_first[d];
          m_mode[d] = 1; m_eng[d] = 0; m_pulse[d] = 1;
        end
        1: if (m_pulse[d]) m_pulse[d] = 0;
           else if (m_eng[d] == 2) begin
             if (prga_fail)
               m_mode[d] = (m_key[d] == k_last[d]) ? 3 : 4;
             else if (phase_done[2]) m_mode[d] = 2;
           end else if (phase_done[m_eng[d]]) begin
             m_eng[d]++; m_pulse[d] = 1;
           end
        4: begin
          m_key[d] = m_key[d] + 24'd1;
          m_mode[d] = 1; m_eng[d] = 0; m_pulse[d] = 1;
        end
        default: m_mode[d] = 0;
      endcase
    end
  endtask

  task automatic check_dut(input int d);
    logic       run;
    logic [2:0] oh;
    run = (m_mode[d] == 1);
    oh = run ? 3'(1 << m_eng[d]) : 3'b000;
    chk($sformatf("d%0d_start", d), 32'(ps[d]),
        32'(m_pulse[d] && run ? oh : 3'b000));
    chk($sformatf("d%0d_led", d), 32'(led[d]), 32'(oh));
    chk($sformatf("d%0d_key", d), 32'(ky[d]), 32'(m_key[d]));
    chk($sformatf("d%0d_flags", d), {29'd0, bz[d], kf[d], kx[d]},
        {29'd0, run || m_mode[d] == 4, m_mode[d] == 2, m_mode[d] == 3});
    chk($sformatf("d%0d_mem", d), {15'd0, mw[d], ma[d], md[d]},
        run ? {15'd0, eng_wren[m_eng[d]],
               8'(eng_addr >> (8 * m_eng[d])),
               8'(eng_data >> (8 * m_eng[d]))} : 32'd0);
  endtask

  task automatic edge_only();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    edge_only();
  endtask

  task automatic quiet();
    go = 0; phase_done = 0; prga_fail = 0;
  endtask

  task automatic pulse_done(input int i);
    phase_done = 3'(1 << i); tick(); quiet(); tick();
  endtask

  initial begin
    k_first[0] = 24'h0; k_last[0] = 24'h3FFFFF;
    k_first[1] = 24'h3; k_last[1] = 24'h3;
    reset_n = 0; quiet();
    eng_addr = 24'h332211; eng_data = 24'hccbbaa; eng_wren = 0;
    edge_only(); edge_only();
    reset_n = 1; tick();
    chk("rst_idle", {29'd0, bz[0], kf[0], kx[0]}, 32'd0);

    // 1: go for one cycle, owner mux with all engines writing
    go = 1; tick(); quiet();
    chk("t1_start", 32'(ps[0]), 32'h1);
    eng_wren = 3'b111; eng_addr = 24'h775511;
    tick();
    chk("t1_start_gone", 32'(ps[0]), 32'h0);
    chk("t1_mem", {23'd0, mw[0], ma[0]}, 32'h111);
    tick(); tick();

    // 2: full pass on key 0
    pulse_done(0);
    pulse_done(1); tick();
    pulse_done(2);
    chk("t2_found", {8'd0, kf[0], ky[0]}, 32'h0100_0000);

    // 3: two fails then success
    go = 1; tick(); quiet(); tick();
    for (int k = 0; k < 2; k++) begin
      pulse_done(0); pulse_done(1);
      prga_fail = 1; tick(); quiet(); tick(); tick();
    end
    pulse_done(0); pulse_done(1); pulse_done(2);
    chk("t3_key2", {8'd0, kf[0], ky[0]}, 32'h0100_0002);
    chk("t4_exh", {8'd0, kx[1], ky[1]}, 32'h0100_0003);

    // 5: stray done in WT_INIT, simultaneous fail and done
    go = 1; tick(); quiet(); tick();
    phase_done = 3'b100; tick(); quiet(); tick();
    pulse_done(0); pulse_done(1);
    phase_done = 3'b100; prga_fail = 1; tick(); quiet();
    chk("t5_not_found", 32'(kf[0]), 32'h0);
    tick();
    chk("t5_key1", 32'(ky[0]), 32'h1);

    // 6: reset in WT_KSA, then rerun from KEY_FIRST
    tick(); pulse_done(0); tick();
    reset_n = 0; tick(); reset_n = 1;
    chk("t6_zero", {5'd0, ps[0], led[0], mw[0], bz[0], ky[0]}, 32'd0);
    tick();
    go = 1; tick(); quiet(); tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      go = ($urandom_range(0, 7) == 0);
      phase_done = 3'($urandom) & 3'($urandom);
      prga_fail = ($urandom_range(0, 5) == 0);
      eng_addr = 24'($urandom);
      eng_data = 24'($urandom);
      eng_wren = 3'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
